// File: rtl/qed_commit_checker.sv
// Mirrors QED original/duplicate register writes and checks that the duplicate stream matches the original stream.
// Latency: shadows and counts update 1 cycle after a write; a check reports done/pass 16 cycles after acceptance.
// Backpressure: none; writes are captured every cycle, and check requests outside IDLE or failing the gate are dropped.
module qed_commit_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_waddr_i,
    input  logic [31:0]      wb_wdata_i,
    input  logic             wb_qed_vld_i,
    input  logic             check_en_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             mismatch_o,
    output logic [3:0]       mismatch_idx_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] orig_cnt_o,
    output logic [CNT_W-1:0] dup_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic        fail, fail_nxt;
    logic        dirty, dirty_nxt;
    logic [3:0]  fail_idx, fail_idx_nxt;
    logic        busy_nxt, done_nxt, pass_nxt, mis_nxt;
    logic [3:0]  mis_idx_nxt;

    logic [31:0] orig_sh [1:15];
    logic [31:0] dup_sh  [1:15];

    logic wr_acc, orig_hit, dup_hit, pair_neq;

    // Addresses 0 and 16 decode to index 0 and are never mirrored.
    assign wr_acc   = wb_we_i & wb_qed_vld_i;
    assign orig_hit = wr_acc & ~wb_waddr_i[4] & (wb_waddr_i[3:0] != 4'd0);
    assign dup_hit  = wr_acc &  wb_waddr_i[4] & (wb_waddr_i[3:0] != 4'd0);
    assign pair_neq = (orig_sh[idx] != dup_sh[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 15; i++) begin
                orig_sh[i] <= '0;
                dup_sh[i]  <= '0;
            end
            orig_cnt_o <= '0;
            dup_cnt_o  <= '0;
            ovf_o      <= 1'b0;
        end else begin
            if (orig_hit) begin
                orig_sh[wb_waddr_i[3:0]] <= wb_wdata_i;
                if (orig_cnt_o == CNT_MAX) ovf_o <= 1'b1;
                else                       orig_cnt_o <= orig_cnt_o + 1'b1;
            end
            if (dup_hit) begin
                dup_sh[wb_waddr_i[3:0]] <= wb_wdata_i;
                if (dup_cnt_o == CNT_MAX) ovf_o <= 1'b1;
                else                      dup_cnt_o <= dup_cnt_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= 4'd1;
            fail           <= 1'b0;
            dirty          <= 1'b0;
            fail_idx       <= 4'd0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            mismatch_o     <= 1'b0;
            mismatch_idx_o <= 4'd0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            fail           <= fail_nxt;
            dirty          <= dirty_nxt;
            fail_idx       <= fail_idx_nxt;
            busy_o         <= busy_nxt;
            done_o         <= done_nxt;
            pass_o         <= pass_nxt;
            mismatch_o     <= mis_nxt;
            mismatch_idx_o <= mis_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        fail_nxt     = fail;
        dirty_nxt    = dirty;
        fail_idx_nxt = fail_idx;
        busy_nxt     = busy_o;
        done_nxt     = 1'b0;
        pass_nxt     = 1'b0;
        mis_nxt      = mismatch_o;
        mis_idx_nxt  = mismatch_idx_o;
        case (state)
            IDLE: begin
                if (check_en_i && (orig_cnt_o == dup_cnt_o) &&
                    (orig_cnt_o != '0) && !ovf_o) begin
                    state_nxt = SCAN;
                    idx_nxt   = 4'd1;
                    fail_nxt  = 1'b0;
                    dirty_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SCAN: begin
                // A write during the scan invalidates the verdict either way.
                if (orig_hit || dup_hit) dirty_nxt = 1'b1;
                if (pair_neq && !fail) begin
                    fail_nxt     = 1'b1;
                    fail_idx_nxt = idx;
                end
                if (idx == 4'd15) state_nxt = DONE;
                else              idx_nxt   = idx + 4'd1;
            end
            DONE: begin
                done_nxt  = 1'b1;
                pass_nxt  = !fail && !dirty;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                if (fail && !dirty) begin
                    mis_nxt = 1'b1;
                    if (!mismatch_o) mis_idx_nxt = fail_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/qed_commit_checker.md
# qed_commit_checker

Downstream of the core's register writeback port in the SQED verification build. Snoops every QED-valid architectural register write, mirrors original registers x1–x15 and duplicate registers x17–x31 into shadow banks, and counts original and duplicate commits. On request, once both counts are equal and non-zero, scans the 15 register pairs one per cycle and reports whether the duplicate stream reproduced the original results. Its pass/mismatch outputs are the properties the formal SQED harness asserts.

## Interface
- CNT_W, 16, width of each commit counter.
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- wb_we_i  in  1  register-file write enable from the execute stage.
- wb_waddr_i  in  5  register write address.
- wb_wdata_i  in  32  register write data.
- wb_qed_vld_i  in  1  the write belongs to a QED-valid instruction (the id_ex-stage valid).
- check_en_i  in  1  request a consistency check.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse when a scan ends.
- pass_o  out  1  one-cycle pulse, coincident with done_o, when the scan found all pairs equal.
- mismatch_o  out  1  sticky; set by any failing scan.
- mismatch_idx_o  out  4  pair index (1–15) of the first failing pair of the first failing scan; 0 if none.
- ovf_o  out  1  sticky; a counter saturated.
- orig_cnt_o  out  CNT_W  original-register commit count.
- dup_cnt_o  out  CNT_W  duplicate-register commit count.

## Operation
- Accepted write: wb_we_i & wb_qed_vld_i.
  - waddr 1–15 updates orig[waddr] and increments orig_cnt.
  - waddr 17–31 updates dup[waddr-16] and increments dup_cnt.
  - waddr 0 and 16 are ignored: no shadow update, no count.
- Shadows reset to 0, matching the register file reset. Writes are captured in every state.
- Counters saturate at 2^CNT_W-1. An accepted write that would exceed this leaves the counter at max and sets ovf_o.
- FSM states:
  - IDLE. Moves to SCAN when check_en_i & (orig_cnt==dup_cnt) & (orig_cnt!=0) & !ovf_o. Loads idx=1, clears the fail and dirty flags, sets busy_o. A request that does not meet these conditions is dropped with no pulse.
  - SCAN. Compares the registered orig[idx] against dup[idx].
    - On the first inequality, records idx as the fail index and sets the fail flag.
    - Any accepted write to waddr 1–15 or 17–31 while in SCAN sets the dirty flag.
    - At idx=15, moves to DONE; otherwise idx increments.
  - DONE. For one cycle, drives done_o=1 and pass_o=!fail & !dirty.
    - If fail & !dirty: sets mismatch_o. If mismatch_o was previously 0, also loads mismatch_idx_o.
    - A dirty scan reports neither pass nor mismatch.
    - Returns to IDLE. busy_o clears.
- check_en_i is ignored outside IDLE.
- mismatch_o, mismatch_idx_o and ovf_o clear only on rst.

## Timing
- All outputs are registered.
- Reset values:
  - busy_o=0, done_o=0, pass_o=0, mismatch_o=0, ovf_o=0.
  - mismatch_idx_o=0, orig_cnt_o=0, dup_cnt_o=0.
  - State IDLE, idx=1, all shadows 0.
- Shadow and counter update: visible the cycle after the write.
- Comparisons read pre-edge shadow values. A write in the same cycle as the compare of that index is not seen by that compare, but it marks the scan dirty.
- Check latency: with check_en_i sampled high at edge E0:
  - busy_o=1 after E0.
  - Pairs 1..15 are compared over the following 15 cycles.
  - done_o/pass_o go high after edge E16 for exactly one cycle, together with busy_o falling.
  - A new check can be accepted at E17.
- Counter condition: uses pre-edge counts. A write at E0 does not affect acceptance at E0.
- Reset mid-scan: rst at any edge returns to the full reset state. No done_o is produced for the aborted scan.
- Simultaneous write at max count and check request: ovf_o is set at that edge, and the check is still accepted only if ovf_o was 0 pre-edge.

## Test plan
- Equal streams, scan passes:
  - Stimulus: writes x1=0x11, x17=0x11, x5=0xDEADBEEF, x21=0xDEADBEEF, then check_en_i.
  - Required: busy_o for 16 cycles, done_o=pass_o=1 at E16, mismatch_o=0, counts 2/2.
- Mismatch detected:
  - Stimulus: x3=5, x19=6, x7=9, x23=8, then check_en_i.
  - Required: done_o=1, pass_o=0, mismatch_o=1, mismatch_idx_o=3. A second identical check leaves mismatch_idx_o=3.
- Gating and ignored addresses:
  - Stimulus 1: writes x0 and x16, then check_en_i. Required: counts stay 0, no busy_o, no done_o.
  - Stimulus 2: x1 only, then check_en_i. Required: counts 1/0, request dropped.
  - Stimulus 3: wb_qed_vld_i=0 writes. Required: no effect.
- Dirty scan:
  - Stimulus: equal pair x2/x18, check accepted, then write x4 during SCAN.
  - Required: done_o=1, pass_o=0, mismatch_o=0. A re-check after matching x20 passes.
- Overflow, CNT_W=2:
  - Stimulus: four writes to x1.
  - Required: orig_cnt_o=3, ovf_o=1, and later check_en_i is ignored even with dup_cnt=3.
- Reset mid-scan:
  - Stimulus: rst asserted at cycle 7 of a scan.
  - Required: next cycle busy_o=0, counts 0, shadows 0, and no done_o is ever emitted for that scan.
